cpu_boot_loader: RTL and testbench

Boot-time program loader and reset sequencer for the pipeline CPU. It receives a program as a byte stream over a valid/ready handshake and assembles bytes into 32-bit instruction words. It writes each word into the CPU instruction memory through the `initialize` / `instruction_initialize_address` / `instruction_initialize_data` port, holding the CPU in reset throughout. After the last word it releases the CPU to run from address 0.

---
 rtl/cpu_boot_loader.sv | 200 ++++++++++++++++++++
 tb/tb_cpu_boot_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_loader.sv
// -----------------------------------------------------------------------------
// cpu_boot_loader
//
// Boot-time program loader and reset sequencer for the pipeline CPU.
// A program arrives as a little-endian byte stream over a valid/ready
// handshake. Every four bytes form one 32-bit instruction word, which is
// written into the CPU instruction memory through the initialize port while
// the CPU is held in reset. After the last word and a short settling delay,
// the CPU is released to run from address 0.
//
// Parameters
//   DEPTH_WORDS  instruction memory capacity in words (longest legal program)
//   RUN_DELAY    cycles between the last write and CPU reset release (1..15)
//
// Ports
//   clk                             system clock, rising edge
//   rst                             asynchronous active-low reset
//   start                           single-cycle load request (IDLE/RUN/ERR)
//   word_count[7:0]                 program length in words, sampled on start
//   in_valid / in_data[7:0]         byte stream from the program source
//   in_ready                        byte stream ready, high only while collecting
//   cpu_rst                         CPU reset, active-high
//   initialize                      instruction memory write strobe
//   instruction_initialize_address  byte address of the word being written
//   instruction_initialize_data     instruction word being written
//   busy                            load in progress (COLLECT, WRITE, RELEASE)
//   done                            CPU running (RUN)
//   error                           rejected program length (ERR)
// -----------------------------------------------------------------------------
module cpu_boot_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int RUN_DELAY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cpu_rst,
  output logic        initialize,
  output logic [31:0] instruction_initialize_address,
  output logic [31:0] instruction_initialize_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [8:0] DEPTH_W9    = 9'(DEPTH_WORDS);
  localparam logic [3:0] RUN_DELAY_C = 4'(RUN_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RELEASE,
    S_RUN,
    S_ERR
  } state_e;

  state_e      state_q,    state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  k_q,        k_d;
  logic [7:0]  left_q,     left_d;
  logic [31:0] asm_q,      asm_d;
  logic [3:0]  delay_q,    delay_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] data_q,     data_d;

  logic in_ready_q, in_ready_d;
  logic cpu_rst_q,  cpu_rst_d;
  logic init_q,     init_d;
  logic busy_q,     busy_d;
  logic done_q,     done_d;
  logic error_q,    error_d;

  logic len_bad;

  // Length is validated up front so the write address can never leave memory.
  assign len_bad = (word_count == 8'd0) || ({1'b0, word_count} > DEPTH_W9);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    k_d        = k_q;
    left_d     = left_q;
    asm_d      = asm_q;
    delay_d    = delay_q;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          if (len_bad) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_COLLECT;
            k_d        = 8'd0;
            left_d     = word_count;
            byte_idx_d = 2'd0;
          end
        end
      end

      S_COLLECT: begin
        if (in_valid && in_ready_q) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          if (byte_idx_q == 2'd3) begin
            // The final byte goes straight into the write register so the
            // word is presented in the very next cycle.
            state_d    = S_WRITE;
            byte_idx_d = 2'd0;
            data_d     = {in_data, asm_q[23:0]};
            addr_d     = {22'd0, k_q, 2'b00};
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        k_d    = k_q + 8'd1;
        left_d = left_q - 8'd1;
        if (left_q == 8'd1) begin
          state_d = S_RELEASE;
          delay_d = RUN_DELAY_C;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_RELEASE: begin
        // RELEASE lasts exactly RUN_DELAY cycles.
        if (delay_q <= 4'd1) begin
          delay_d = 4'd0;
          state_d = S_RUN;
        end else begin
          delay_d = delay_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d == S_COLLECT);
    cpu_rst_d  = (state_d != S_RUN);
    init_d     = (state_d == S_WRITE);
    busy_d     = (state_d == S_COLLECT) || (state_d == S_WRITE) ||
                 (state_d == S_RELEASE);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      k_q        <= 8'd0;
      left_q     <= 8'd0;
      asm_q      <= 32'd0;
      delay_q    <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      init_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      k_q        <= k_d;
      left_q     <= left_d;
      asm_q      <= asm_d;
      delay_q    <= delay_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      init_q     <= init_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready                       = in_ready_q;
  assign cpu_rst                        = cpu_rst_q;
  assign initialize                     = init_q;
  assign instruction_initialize_address = addr_q;
  assign instruction_initialize_data    = data_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign error                          = error_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_boot_loader
//
// Self-checking bench for cpu_boot_loader. Expected instruction-memory writes
// are queued as bytes are driven; a monitor records every initialize pulse
// with its cycle number, and each scenario task compares the two.
// -----------------------------------------------------------------------------
module tb_cpu_boot_loader;

  localparam int DEPTH     = 64;
  localparam int RUN_DELAY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cpu_rst;
  logic        initialize;
  logic [31:0] addr;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        error;

  logic [5:0]  flags;
  assign flags = {in_ready, cpu_rst, initialize, busy, done, error};

  // flags = {in_ready, cpu_rst, initialize, busy, done, error}
  localparam logic [5:0] F_IDLE    = 6'b010000;
  localparam logic [5:0] F_COLLECT = 6'b110100;
  localparam logic [5:0] F_RUN     = 6'b000010;
  localparam logic [5:0] F_ERR     = 6'b010001;

  cpu_boot_loader #(
    .DEPTH_WORDS (DEPTH),
    .RUN_DELAY   (RUN_DELAY)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .word_count                     (word_count),
    .in_valid                       (in_valid),
    .in_data                        (in_data),
    .in_ready                       (in_ready),
    .cpu_rst                        (cpu_rst),
    .initialize                     (initialize),
    .instruction_initialize_address (addr),
    .instruction_initialize_data    (data),
    .busy                           (busy),
    .done                           (done),
    .error                          (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write pulse seen by the CPU memory.
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];
  int          obs_c[$];
  always @(negedge clk) begin
    if (initialize === 1'b1) begin
      obs_a.push_back(addr);
      obs_d.push_back(data);
      obs_c.push_back(cyc);
    end
  end

  // Scoreboard of expected writes.
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  logic [31:0] prog [0:63];
  int errors = 0;
  int checks = 0;

  // Called at a negedge; returns at the negedge after the byte is consumed.
  task automatic send_byte(input logic [7:0] b, input bit bubble);
    int n;
    if (bubble) begin
      in_valid = 1'b0;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL byte_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input bit bubble);
    exp_a.push_back(a);
    exp_d.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], bubble);
  endtask

  task automatic start_load(input logic [7:0] wc, output int s);
    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    in_valid   = 1'b0;
    s          = cyc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_run(output int c);
    c = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cpu_rst === 1'b0) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (flags !== F_IDLE) begin
      errors++;
      $display("FAIL reset_flags: flags=%b required %b", flags, F_IDLE);
    end
    checks++;
    if (addr !== 32'd0 || data !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr_data: addr=%08h data=%08h required 0/0", addr, data);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (flags !== F_IDLE) begin
      errors++;
      $display("FAIL idle_after_reset: flags=%b required %b", flags, F_IDLE);
    end
  endtask

  task automatic test_load(input int n, input bit bubble, input string tag);
    int s, c, base, k, gap;
    logic [31:0] ea, ed;
    base = obs_a.size();
    gap  = bubble ? 9 : 5;
    start_load(8'(n), s);
    checks++;
    if (flags !== F_COLLECT) begin
      errors++;
      $display("FAIL %s_start: flags=%b required %b", tag, flags, F_COLLECT);
    end
    for (k = 0; k < n; k++) send_word(prog[k], 32'(4 * k), bubble);
    in_valid = 1'b0;
    wait_run(c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL %s_release_timeout: cpu_rst=%b required 0", tag, cpu_rst);
    end
    k = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      checks++;
      if (base + k >= obs_a.size()) begin
        errors++;
        $display("FAIL %s_write%0d: no pulse, required addr=%08h data=%08h", tag, k, ea, ed);
      end else begin
        if (obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
          errors++;
          $display("FAIL %s_write%0d: addr=%08h data=%08h required addr=%08h data=%08h",
                   tag, k, obs_a[base+k], obs_d[base+k], ea, ed);
        end
        if (k > 0) begin
          checks++;
          if (obs_c[base+k] - obs_c[base+k-1] !== gap) begin
            errors++;
            $display("FAIL %s_gap%0d: gap=%0d required %0d", tag, k,
                     obs_c[base+k] - obs_c[base+k-1], gap);
          end
        end
      end
      k++;
    end
    checks++;
    if (obs_a.size() != base + n) begin
      errors++;
      $display("FAIL %s_pulse_count: count=%0d required %0d", tag, obs_a.size() - base, n);
    end
    if (obs_a.size() >= base + n && c >= 0) begin
      checks++;
      if (c !== obs_c[base+n-1] + 1 + RUN_DELAY) begin
        errors++;
        $display("FAIL %s_release_delay: cpu_rst fell at %0d required %0d", tag, c,
                 obs_c[base+n-1] + 1 + RUN_DELAY);
      end
    end
    if (!bubble) begin
      checks++;
      if (c !== s + 1 + 5 * n + RUN_DELAY) begin
        errors++;
        $display("FAIL %s_total_latency: cycles=%0d required %0d", tag, c - s,
                 1 + 5 * n + RUN_DELAY);
      end
    end
    checks++;
    if (flags !== F_RUN) begin
      errors++;
      $display("FAIL %s_run_flags: flags=%b required %b", tag, flags, F_RUN);
    end
    checks++;
    if (addr !== 32'(4 * (n - 1))) begin
      errors++;
      $display("FAIL %s_addr_hold: addr=%08h required %08h", tag, addr, 32'(4 * (n - 1)));
    end
  endtask

  task automatic test_bad_len(input logic [7:0] wc);
    int s, base;
    base = obs_a.size();
    start_load(wc, s);
    checks++;
    if (flags !== F_ERR) begin
      errors++;
      $display("FAIL bad_len_%0d: flags=%b required %b", wc, flags, F_ERR);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs_a.size() != base || flags !== F_ERR) begin
      errors++;
      $display("FAIL bad_len_%0d_hold: pulses=%0d flags=%b required 0 and %b",
               wc, obs_a.size() - base, flags, F_ERR);
    end
  endtask

  task automatic test_reset_midload();
    int s, base;
    logic [31:0] ea, ed;
    base = obs_a.size();
    start_load(8'd4, s);
    send_word(prog[0], 32'd0, 1'b0);
    send_word(prog[1], 32'd4, 1'b0);
    send_byte(prog[2][7:0], 1'b0);
    send_byte(prog[2][15:8], 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (flags !== F_IDLE || addr !== 32'd0 || data !== 32'd0) begin
      errors++;
      $display("FAIL midload_async_reset: flags=%b addr=%08h data=%08h required %b 0 0",
               flags, addr, data, F_IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (flags !== F_IDLE) begin
      errors++;
      $display("FAIL midload_no_release: flags=%b required %b", flags, F_IDLE);
    end
    for (int k = 0; k < 2; k++) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      checks++;
      if (base + k >= obs_a.size() || obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
        errors++;
        $display("FAIL midload_write%0d: pulses=%0d required addr=%08h data=%08h",
                 k, obs_a.size() - base, ea, ed);
      end
    end
    checks++;
    if (obs_a.size() != base + 2) begin
      errors++;
      $display("FAIL midload_pulse_count: count=%0d required 2", obs_a.size() - base);
    end
  endtask

  task automatic test_run_restart();
    int s, c, base;
    logic [31:0] ea, ed;
    base = obs_a.size();
    checks++;
    if (flags !== F_RUN) begin
      errors++;
      $display("FAIL restart_pre: flags=%b required %b", flags, F_RUN);
    end
    prog[0] = 32'h1357_9bdf;
    exp_a.push_back(32'd0);
    exp_d.push_back(prog[0]);
    start_load(8'd1, s);
    checks++;
    if (flags !== F_COLLECT) begin
      errors++;
      $display("FAIL restart_cpu_rst: flags=%b required %b", flags, F_COLLECT);
    end
    send_byte(prog[0][7:0], 1'b0);
    // A bad-length start in COLLECT must have no effect at all.
    in_valid   = 1'b0;
    start      = 1'b1;
    word_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (flags !== F_COLLECT) begin
      errors++;
      $display("FAIL start_ignored: flags=%b required %b", flags, F_COLLECT);
    end
    send_byte(prog[0][15:8], 1'b0);
    send_byte(prog[0][23:16], 1'b0);
    send_byte(prog[0][31:24], 1'b0);
    in_valid = 1'b0;
    wait_run(c);
    ea = exp_a.pop_front();
    ed = exp_d.pop_front();
    checks++;
    if (obs_a.size() != base + 1 || obs_a[base] !== ea || obs_d[base] !== ed) begin
      errors++;
      $display("FAIL restart_write: pulses=%0d required 1 at addr=%08h data=%08h",
               obs_a.size() - base, ea, ed);
    end
    checks++;
    if (c < 0 || flags !== F_RUN) begin
      errors++;
      $display("FAIL restart_run: flags=%b cycle=%0d required %b", flags, c, F_RUN);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    word_count = 8'd0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    #1;
    test_reset();

    prog[0] = 32'h0022_1020;
    prog[1] = 32'h0084_4022;
    prog[2] = 32'h00A6_3825;
    test_load(3, 1'b0, "b2b");
    test_load(3, 1'b1, "bubble");

    test_bad_len(8'd0);
    test_bad_len(8'd65);
    prog[0] = $urandom;
    test_load(1, 1'b0, "after_err");

    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    test_load(DEPTH, 1'b0, "full");

    test_reset_midload();
    prog[0] = 32'hCAFE_0001;
    test_load(1, 1'b0, "after_rst");

    test_run_restart();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
